// File: rtl/switch_out_arbiter.sv
// switch_out_arbiter: shares one NoC switch output port among IN_NUM input
// buffers. Round-robin arbitration picks an owner that then holds a wormhole
// lock until its tail flit is forwarded or the packet exceeds MAX_PACK_LEN.
//
// Ports:
//   clk              clock, all state on rising edge
//   a_rst            synchronous active-high reset
//   req_wr_ready_in  per-input "flit valid"
//   req_data_i       packed flits, input i at [i*FLIT_SIZE +: FLIT_SIZE]
//   req_r_ready_out  per-input pop strobe (flit accepted this cycle)
//   out_r_ready_in   downstream ready
//   out_wr_ready_out flit on data_o is valid
//   data_o           forwarded flit (0 when idle)
//   grant_o          one-hot owner, 0 when idle
//   busy_o           lock held
//   pack_cnt_o       packets forwarded (wrapping)
//   len_err_o        sticky over-length flag
module switch_out_arbiter #(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned ADDR_SIZE    = 4,
    parameter int unsigned IN_NUM       = 5,
    parameter int unsigned MAX_PACK_LEN = 16,
    parameter int unsigned FLIT_SIZE    = DATA_SIZE + ADDR_SIZE + 1
) (
    input  logic                        clk,
    input  logic                        a_rst,
    input  logic [IN_NUM-1:0]           req_wr_ready_in,
    input  logic [IN_NUM*FLIT_SIZE-1:0] req_data_i,
    output logic [IN_NUM-1:0]           req_r_ready_out,
    input  logic                        out_r_ready_in,
    output logic                        out_wr_ready_out,
    output logic [FLIT_SIZE-1:0]        data_o,
    output logic [IN_NUM-1:0]           grant_o,
    output logic                        busy_o,
    output logic [31:0]                 pack_cnt_o,
    output logic                        len_err_o
);

    localparam int unsigned IDX_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_PACK_LEN + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [IN_NUM-1:0]   grant_q,    grant_d;
    logic [IDX_W-1:0]    owner_q,    owner_d;
    logic [IDX_W-1:0]    ptr_q,      ptr_d;
    logic [CNT_W-1:0]    flit_cnt_q, flit_cnt_d;
    logic [31:0]         pack_cnt_q, pack_cnt_d;
    logic                len_err_q,  len_err_d;

    logic [FLIT_SIZE-1:0] owner_flit_c;
    logic                 owner_vld_c;
    logic                 xfer_c;
    logic                 tail_c;
    logic                 pick_found_c;
    logic [IDX_W-1:0]     pick_idx_c;

    // Datapath mux driven by the registered one-hot grant; all-zero grant
    // (idle) yields zero data and no strobes.
    always_comb begin
        owner_flit_c = '0;
        for (int unsigned i = 0; i < IN_NUM; i++) begin
            if (grant_q[i]) begin
                owner_flit_c = owner_flit_c | req_data_i[i*FLIT_SIZE +: FLIT_SIZE];
            end
        end
        owner_vld_c = |(grant_q & req_wr_ready_in);
        xfer_c      = owner_vld_c & out_r_ready_in;
        tail_c      = owner_flit_c[FLIT_SIZE-1];
    end

    // Round-robin search starting one past the previous owner.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int unsigned off = 1; off <= IN_NUM; off++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((32'(ptr_q) + off) % IN_NUM);
            if (!pick_found_c && req_wr_ready_in[cand]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = cand;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        flit_cnt_d = flit_cnt_q;
        pack_cnt_d = pack_cnt_q;
        len_err_d  = len_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found_c) begin
                    state_d = ST_LOCKED;
                    owner_d = pick_idx_c;
                    grant_d = IN_NUM'(1) << pick_idx_c;
                end
            end
            ST_LOCKED: begin
                if (xfer_c) begin
                    flit_cnt_d = flit_cnt_q + CNT_W'(1);
                    if (tail_c) begin
                        pack_cnt_d = pack_cnt_q + 32'd1;
                        ptr_d      = owner_q;
                        flit_cnt_d = '0;
                        grant_d    = '0;
                        state_d    = ST_IDLE;
                    end else if (flit_cnt_q + CNT_W'(1) == CNT_W'(MAX_PACK_LEN)) begin
                        // Over-length packet: drop the lock without counting it.
                        len_err_d  = 1'b1;
                        ptr_d      = owner_q;
                        flit_cnt_d = '0;
                        grant_d    = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= IDX_W'(IN_NUM - 1);
            flit_cnt_q <= '0;
            pack_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            flit_cnt_q <= flit_cnt_d;
            pack_cnt_q <= pack_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign data_o           = owner_flit_c;
    assign out_wr_ready_out = owner_vld_c;
    assign req_r_ready_out  = grant_q & req_wr_ready_in & {IN_NUM{out_r_ready_in}};
    assign grant_o          = grant_q;
    assign busy_o           = (state_q == ST_LOCKED);
    assign pack_cnt_o       = pack_cnt_q;
    assign len_err_o        = len_err_q;

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Directed bench for switch_out_arbiter (IN_NUM=5, MAX_PACK_LEN=4).
module tb_switch_out_arbiter;

    localparam int unsigned DATA_SIZE    = 8;
    localparam int unsigned ADDR_SIZE    = 4;
    localparam int unsigned IN_NUM       = 5;
    localparam int unsigned MAX_PACK_LEN = 4;
    localparam int unsigned FLIT_SIZE    = DATA_SIZE + ADDR_SIZE + 1;

    logic                        clk = 1'b0;
    logic                        a_rst;
    logic [IN_NUM-1:0]           req_wr_ready_in;
    logic [IN_NUM*FLIT_SIZE-1:0] req_data_i;
    logic [IN_NUM-1:0]           req_r_ready_out;
    logic                        out_r_ready_in;
    logic                        out_wr_ready_out;
    logic [FLIT_SIZE-1:0]        data_o;
    logic [IN_NUM-1:0]           grant_o;
    logic                        busy_o;
    logic [31:0]                 pack_cnt_o;
    logic                        len_err_o;

    logic [FLIT_SIZE-1:0] fl [IN_NUM];

    int n_cmp = 0;
    int n_err = 0;

    switch_out_arbiter #(
        .DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .IN_NUM(IN_NUM),
        .MAX_PACK_LEN(MAX_PACK_LEN), .FLIT_SIZE(FLIT_SIZE)
    ) dut (
        .clk(clk), .a_rst(a_rst),
        .req_wr_ready_in(req_wr_ready_in), .req_data_i(req_data_i),
        .req_r_ready_out(req_r_ready_out), .out_r_ready_in(out_r_ready_in),
        .out_wr_ready_out(out_wr_ready_out), .data_o(data_o),
        .grant_o(grant_o), .busy_o(busy_o),
        .pack_cnt_o(pack_cnt_o), .len_err_o(len_err_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < IN_NUM; i++) req_data_i[i*FLIT_SIZE +: FLIT_SIZE] = fl[i];
    end

    function automatic logic [FLIT_SIZE-1:0] mk(input logic t, input logic [3:0] a, input logic [7:0] d);
        return {t, a, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] g, input logic b, input logic wr,
                           input logic [4:0] rr, input logic [FLIT_SIZE-1:0] d);
        chk({tag, "/grant"}, 64'(grant_o), 64'(g));
        chk({tag, "/busy"}, 64'(busy_o), 64'(b));
        chk({tag, "/wr"}, 64'(out_wr_ready_out), 64'(wr));
        chk({tag, "/rr"}, 64'(req_r_ready_out), 64'(rr));
        chk({tag, "/data"}, 64'(data_o), 64'(d));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic v, input logic [FLIT_SIZE-1:0] f);
        req_wr_ready_in[i] = v;
        fl[i] = f;
    endtask

    task automatic clear_in();
        req_wr_ready_in = '0;
        for (int i = 0; i < IN_NUM; i++) fl[i] = '0;
    endtask

    task automatic reset_dut();
        a_rst = 1'b1;
        clear_in();
        out_r_ready_in = 1'b1;
        step();
        step();
        a_rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [IN_NUM];
        int e;

        // Reset values
        reset_dut();
        chk_out("rst", 5'b00000, 1'b0, 1'b0, 5'b00000, '0);
        chk("rst/pack", 64'(pack_cnt_o), 64'd0);
        chk("rst/lenerr", 64'(len_err_o), 64'd0);

        // Inputs 1 and 3 each send a 3-flit packet
        set_in(1, 1'b1, mk(1'b0, 4'h1, 8'hA0));
        set_in(3, 1'b1, mk(1'b0, 4'h3, 8'hB0));
        step(); #1;                                   // edge 1: arbitrate
        chk_out("t1_arb", 5'b00010, 1'b1, 1'b1, 5'b00010, mk(1'b0, 4'h1, 8'hA0));
        step(); set_in(1, 1'b1, mk(1'b0, 4'h1, 8'hA1)); #1;   // edge 2: A0
        chk("t1_a1_data", 64'(data_o), 64'(mk(1'b0, 4'h1, 8'hA1)));
        step(); set_in(1, 1'b1, mk(1'b1, 4'h1, 8'hA2)); #1;   // edge 3: A1
        chk("t1_a2_busy", 64'(busy_o), 64'd1);
        step(); set_in(1, 1'b0, '0); #1;              // edge 4: A2 tail
        chk_out("t1_idle", 5'b00000, 1'b0, 1'b0, 5'b00000, '0);
        chk("t1_pack1", 64'(pack_cnt_o), 64'd1);
        step(); #1;                                   // edge 5: arbitrate input 3
        chk_out("t1_arb3", 5'b01000, 1'b1, 1'b1, 5'b01000, mk(1'b0, 4'h3, 8'hB0));
        step(); set_in(3, 1'b1, mk(1'b0, 4'h3, 8'hB1)); #1;   // edge 6
        step(); set_in(3, 1'b1, mk(1'b1, 4'h3, 8'hB2)); #1;   // edge 7
        chk("t1_b2_pack", 64'(pack_cnt_o), 64'd1);
        step(); set_in(3, 1'b0, '0); #1;              // edge 8: B2 tail
        chk("t1_pack2", 64'(pack_cnt_o), 64'd2);
        chk("t1_end_busy", 64'(busy_o), 64'd0);

        // Fairness: all inputs offer single-flit packets
        reset_dut();
        for (int i = 0; i < IN_NUM; i++) begin
            cnt[i] = 0;
            set_in(i, 1'b1, mk(1'b1, 4'(i), 8'(8'h10 + i)));
        end
        for (int n = 0; n < 10; n++) begin
            e = n % IN_NUM;
            step(); #1;
            chk("fair_grant", 64'(grant_o), 64'(5'b00001 << e));
            chk("fair_data", 64'(data_o), 64'(mk(1'b1, 4'(e), 8'(8'h10 + e))));
            for (int k = 0; k < IN_NUM; k++) if (grant_o[k]) cnt[k]++;
            step();
            if (n == 9) clear_in();
            #1;
            chk("fair_rel", 64'(busy_o), 64'd0);
        end
        for (int k = 0; k < IN_NUM; k++) chk("fair_cnt", 64'(cnt[k]), 64'd2);
        chk("fair_pack", 64'(pack_cnt_o), 64'd10);

        // Back-pressure mid-packet on a 4-flit packet from input 2 (ptr = 4)
        set_in(2, 1'b1, mk(1'b0, 4'h2, 8'hC0));
        step(); #1;
        chk("bp_arb", 64'(grant_o), 64'(5'b00100));
        step(); set_in(2, 1'b1, mk(1'b0, 4'h2, 8'hC1)); out_r_ready_in = 1'b0; #1;
        for (int s = 0; s < 4; s++) begin
            chk_out("bp_stall", 5'b00100, 1'b1, 1'b1, 5'b00000, mk(1'b0, 4'h2, 8'hC1));
            step(); #1;
        end
        out_r_ready_in = 1'b1; #1;
        chk("bp_resume_rr", 64'(req_r_ready_out), 64'(5'b00100));
        step(); set_in(2, 1'b1, mk(1'b0, 4'h2, 8'hC2)); #1;
        step(); set_in(2, 1'b1, mk(1'b1, 4'h2, 8'hC3)); #1;
        chk("bp_before_tail", 64'({busy_o, len_err_o}), 64'(2'b10));
        step(); set_in(2, 1'b0, '0); #1;
        chk("bp_pack", 64'(pack_cnt_o), 64'd11);
        chk("bp_lenerr", 64'(len_err_o), 64'd0);

        // Owner gap: input 2 drops valid while input 0 requests (ptr = 2)
        set_in(2, 1'b1, mk(1'b0, 4'h2, 8'hD0));
        step(); #1;
        chk("gap_arb", 64'(grant_o), 64'(5'b00100));
        step(); set_in(2, 1'b0, mk(1'b0, 4'h2, 8'hD1)); set_in(0, 1'b1, mk(1'b1, 4'h0, 8'hE5)); #1;
        for (int s = 0; s < 3; s++) begin
            chk("gap_grant", 64'(grant_o), 64'(5'b00100));
            chk("gap_wr", 64'({out_wr_ready_out, req_r_ready_out}), 64'd0);
            step(); #1;
        end
        set_in(2, 1'b1, mk(1'b0, 4'h2, 8'hD1)); #1;
        chk("gap_resume", 64'(data_o), 64'(mk(1'b0, 4'h2, 8'hD1)));
        step(); set_in(2, 1'b1, mk(1'b1, 4'h2, 8'hD2)); #1;
        chk("gap_still2", 64'(grant_o), 64'(5'b00100));
        step(); set_in(2, 1'b0, '0); #1;
        chk("gap_idle", 64'({busy_o, grant_o}), 64'd0);
        chk("gap_pack", 64'(pack_cnt_o), 64'd12);
        step(); #1;
        chk_out("gap_arb0", 5'b00001, 1'b1, 1'b1, 5'b00001, mk(1'b1, 4'h0, 8'hE5));
        step(); set_in(0, 1'b0, '0); #1;
        chk("gap_pack0", 64'(pack_cnt_o), 64'd13);

        // Over-length: input 0 sends 4 flits without tail (ptr = 0)
        set_in(0, 1'b1, mk(1'b0, 4'h0, 8'h60));
        step(); #1;
        chk("ol_arb", 64'(grant_o), 64'(5'b00001));
        for (int f = 0; f < 3; f++) begin
            step(); set_in(0, 1'b1, mk(1'b0, 4'h0, 8'(8'h61 + f))); #1;
            chk("ol_mid", 64'({busy_o, len_err_o}), 64'(2'b10));
        end
        step();
        set_in(1, 1'b1, mk(1'b0, 4'h1, 8'h70));
        set_in(4, 1'b1, mk(1'b0, 4'h4, 8'h74));
        #1;
        chk("ol_lenerr", 64'(len_err_o), 64'd1);
        chk("ol_idle", 64'({busy_o, grant_o}), 64'd0);
        chk("ol_pack", 64'(pack_cnt_o), 64'd13);
        step(); #1;
        chk("ol_next", 64'(grant_o), 64'(5'b00010));

        // Reset mid-packet: input 1 transfers 2 of 5 flits
        set_in(0, 1'b0, '0);
        set_in(4, 1'b0, '0);
        step(); set_in(1, 1'b1, mk(1'b0, 4'h1, 8'h71)); #1;
        step(); #1;
        chk("mr_busy", 64'(busy_o), 64'd1);
        a_rst = 1'b1;
        set_in(1, 1'b0, '0);
        set_in(2, 1'b1, mk(1'b1, 4'h2, 8'h82));
        set_in(4, 1'b1, mk(1'b1, 4'h4, 8'h84));
        step(); #1;
        chk_out("mr_rst", 5'b00000, 1'b0, 1'b0, 5'b00000, '0);
        chk("mr_pack", 64'(pack_cnt_o), 64'd0);
        chk("mr_lenerr", 64'(len_err_o), 64'd0);
        a_rst = 1'b0;
        step(); #1;
        chk_out("mr_arb", 5'b00100, 1'b1, 1'b1, 5'b00100, mk(1'b1, 4'h2, 8'h82));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/switch_out_arbiter.md
# switch_out_arbiter

Per-output-port packet arbiter for the NoC switch. It shares one switch output port (toward a neighbour or the local IP) among IN_NUM input buffers using round-robin arbitration. The winner holds a packet-level (wormhole) lock until its tail flit is transferred. It also counts forwarded packets and flags over-length packets.

## Interface
Parameters:
- DATA_SIZE, 8, payload bits per flit
- ADDR_SIZE, 4, destination address bits per flit
- IN_NUM, 5, number of requesting input buffers (ports_num + local IP)
- MAX_PACK_LEN, 16, maximum flits per packet before forced release
- FLIT_SIZE, DATA_SIZE+ADDR_SIZE+1, derived; bit [FLIT_SIZE-1] is the tail flag

Ports:
- clk  in  1  clock; all state updates on rising edge
- a_rst  in  1  reset, synchronous, active-high
- req_wr_ready_in  in  IN_NUM  input i holds a valid flit
- req_data_i  in  IN_NUM*FLIT_SIZE  flit of input i at [i*FLIT_SIZE +: FLIT_SIZE]
- req_r_ready_out  out  IN_NUM  pop strobe to input i (flit accepted)
- out_r_ready_in  in  1  downstream can accept a flit
- out_wr_ready_out  out  1  flit on data_o is valid
- data_o  out  FLIT_SIZE  forwarded flit
- grant_o  out  IN_NUM  one-hot current owner, 0 when idle
- busy_o  out  1  lock held
- pack_cnt_o  out  32  packets forwarded (tail flits transferred)
- len_err_o  out  1  sticky over-length flag

## Operation
- Transfer on a rising edge where out_wr_ready_out and out_r_ready_in are both 1. Each transfer is one flit.
- States: IDLE, LOCKED.
- IDLE:
  - No output is asserted.
  - If any req_wr_ready_in bit is set, choose the first set index searching ptr+1, ptr+2, … with wrap modulo IN_NUM.
  - Register the choice in grant and go to LOCKED.
  - If no bit is set, stay in IDLE.
- LOCKED with owner g:
  - data_o = req_data_i[g].
  - out_wr_ready_out = req_wr_ready_in[g].
  - req_r_ready_out[g] = out_r_ready_in & req_wr_ready_in[g]; all other bits are 0.
  - These are combinational from registered grant.
- Each transfer increments flit_cnt, a counter of width clog2(MAX_PACK_LEN+1).
- Transfer with tail bit = 1:
  - pack_cnt_o increments by 1.
  - ptr ← g, flit_cnt ← 0, state → IDLE.
- Transfer with tail bit = 0 where flit_cnt+1 == MAX_PACK_LEN:
  - Forced release: len_err_o ← 1, ptr ← g, flit_cnt ← 0, state → IDLE.
  - pack_cnt_o is not incremented.
- Owner deasserts req_wr_ready_in mid-packet: the lock holds and out_wr_ready_out drops. No other input may interleave.
- Requests of non-owners while LOCKED are ignored; they cannot alter grant or ptr.
- pack_cnt_o wraps from 2^32-1 to 0.
- data_o is 0 when IDLE.

## Timing
- Reset values:
  - state = IDLE, ptr = IN_NUM-1 (first search starts at input 0), flit_cnt = 0.
  - grant_o = 0, busy_o = 0, out_wr_ready_out = 0, req_r_ready_out = 0.
  - data_o = 0, pack_cnt_o = 0, len_err_o = 0.
- Reset asserted mid-packet: the lock is abandoned at that edge. The next cycle is IDLE with all outputs at reset values. The partial packet is not counted.
- Request to grant: 1 cycle. A request sampled in IDLE at edge k gives grant_o/busy_o valid after edge k, and the first transfer can occur at edge k+1.
- Throughput: an N-flit packet with no stalls occupies N+1 cycles (1 arbitration plus N transfers). After a tail transfer the block always spends one IDLE cycle.
- A tail transfer and new requests at the same edge: the new requests are arbitrated in the following IDLE cycle using the updated ptr.
- Single-flit packet (tail bit set on the head flit) releases after 1 transfer.
- busy_o = (state == LOCKED); grant_o = 0 whenever IDLE.

## Test plan
- Reset then inputs 1 and 3 each request a 3-flit packet simultaneously:
  - input 1 granted first; 3 transfers, then IDLE; then input 3 granted.
  - pack_cnt_o = 2 after 8 cycles from the first request with out_r_ready_in held at 1.
- Fairness: all 5 inputs continuously offer 1-flit packets for 10 grants → grant order 0,1,2,3,4,0,1,2,3,4; each input gets exactly 2.
- Back-pressure: out_r_ready_in = 0 for 4 cycles mid-packet → data_o stable, req_r_ready_out all 0, flit_cnt frozen; on release the transfers resume with no loss or duplication.
- Owner gap with a competing requester: input 2 drops valid for 3 cycles mid-packet while input 0 requests → grant_o stays one-hot on input 2; input 0 is served only after input 2's tail transfers.
- Over-length: MAX_PACK_LEN = 4, input 0 sends 4 flits without the tail bit → len_err_o = 1 after the 4th transfer; state IDLE; pack_cnt_o unchanged; next grant goes to the next requester after input 0.
- Reset mid-packet after 2 of 5 flits → all outputs at reset values the next cycle; pack_cnt_o = 0; the first subsequent grant goes to the lowest-indexed requester.
